// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: one round per clock, AES-128 or AES-256 via KEY_BITS, on-the-fly key schedule.
// Define AES_ABORT_EN to add an abort input that discards the in-flight block.
module aes_iter_core #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
`ifdef AES_ABORT_EN
  input  logic                abort,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam int unsigned NR = (KEY_BITS == 128) ? 10 : 14;

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $fatal(1, "aes_iter_core: KEY_BITS must be 128 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 via an addition chain, then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, t, inv;
    a2  = gf_mul(a, a);
    a3  = gf_mul(a2, a);
    a6  = gf_mul(a3, a3);
    a12 = gf_mul(a6, a6);
    t   = gf_mul(a12, a3);
    for (int i = 0; i < 4; i++) t = gf_mul(t, t);
    inv = gf_mul(gf_mul(t, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [15:0][7:0] b;
    b = s;
    for (int i = 0; i < 16; i++) b[4'(i)] = sbox(b[4'(i)]);
    return b;
  endfunction

  // Byte k of the block (k = 4*col + row) lives in element 15-k.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [15:0][7:0] a, o;
    a = s;
    o = a;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4'(15 - 4*c - r)] = a[4'(15 - 4*((c + r) % 4) - r)];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [15:0][7:0] a, o;
    logic [7:0] a0, a1, a2, a3;
    a = s;
    o = a;
    for (int c = 0; c < 4; c++) begin
      a0 = a[4'(15 - 4*c)];
      a1 = a[4'(14 - 4*c)];
      a2 = a[4'(13 - 4*c)];
      a3 = a[4'(12 - 4*c)];
      o[4'(15 - 4*c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[4'(14 - 4*c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[4'(13 - 4*c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[4'(12 - 4*c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  state_t              state_q, state_d;
  logic [127:0]        st_q, st_d, sr, mc, round_out, round_key, out_d;
  logic [KEY_BITS-1:0] key_q, key_d, key_nxt;
  logic [7:0]          rcon_q, rcon_d;
  logic [3:0]          rcount_q, rcount_d;
  logic                rcon_step, last, load;

  assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign last      = (rcount_q == 4'(NR));
  assign sr        = shift_rows(sub_bytes(st_q));
  assign mc        = mix_columns(sr);
  assign round_out = (last ? sr : mc) ^ round_key;

  generate
    if (KEY_BITS == 128) begin : g_ks128
      logic [31:0] t, n0, n1, n2, n3;
      always_comb begin
        t  = sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h0};
        n0 = key_q[127:96] ^ t;
        n1 = key_q[95:64] ^ n0;
        n2 = key_q[63:32] ^ n1;
        n3 = key_q[31:0] ^ n2;
        round_key = {n0, n1, n2, n3};
        key_nxt   = {n0, n1, n2, n3};
        rcon_step = 1'b1;
      end
    end else begin : g_ks256
      logic [31:0] t, t2, u0, u1, u2, u3, l0, l1, l2, l3;
      // Odd rounds use the lower half as-is; even rounds advance the whole window.
      always_comb begin
        t  = sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h0};
        u0 = key_q[255:224] ^ t;
        u1 = key_q[223:192] ^ u0;
        u2 = key_q[191:160] ^ u1;
        u3 = key_q[159:128] ^ u2;
        t2 = sub_word(u3);
        l0 = key_q[127:96] ^ t2;
        l1 = key_q[95:64] ^ l0;
        l2 = key_q[63:32] ^ l1;
        l3 = key_q[31:0] ^ l2;
        round_key = {u0, u1, u2, u3};
        key_nxt   = {u0, u1, u2, u3, l0, l1, l2, l3};
        rcon_step = 1'b1;
        if (rcount_q[0]) begin
          round_key = key_q[127:0];
          key_nxt   = key_q;
          rcon_step = 1'b0;
        end
      end
    end
  endgenerate

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    key_d    = key_q;
    rcount_d = rcount_q;
    rcon_d   = rcon_q;
    out_d    = out_data;
    load     = 1'b0;
    case (state_q)
      IDLE: load = in_valid;
      ROUND: begin
        st_d     = round_out;
        key_d    = key_nxt;
        rcount_d = rcount_q + 4'd1;
        if (rcon_step) rcon_d = xtime(rcon_q);
        if (last) begin
          out_d    = round_out;
          rcount_d = 4'd0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      st_d     = in_data ^ in_key[KEY_BITS-1 -: 128];
      key_d    = in_key;
      rcount_d = 4'd1;
      rcon_d   = 8'h01;
      state_d  = ROUND;
    end
`ifdef AES_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      out_d    = 128'h0;
      rcount_d = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      st_q      <= 128'h0;
      key_q     <= '0;
      rcount_q  <= 4'd0;
      rcon_q    <= 8'h00;
      out_data  <= 128'h0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      key_q     <= key_d;
      rcount_q  <= rcount_d;
      rcon_q    <= rcon_d;
      out_data  <= out_d;
      out_valid <= (state_d == DONE);
      busy      <= (state_d == ROUND);
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: AES-128 and AES-256 instances against FIPS-197 vectors and an
// array-based reference cipher; covers backpressure, input jitter, reset and (AES_ABORT_EN) abort.
module tb_aes_iter_core;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   in_valid, out_ready;
  wire  [1:0]   in_ready, out_valid, busy;
  logic [127:0] in_data0, in_data1, in_key0;
  logic [255:0] in_key1;
  wire  [127:0] out_data0, out_data1;
`ifdef AES_ABORT_EN
  logic [1:0]   abort;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_iter_core #(.KEY_BITS(128)) u_aes128 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data0), .in_key(in_key0),
`ifdef AES_ABORT_EN
    .abort(abort[0]),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data0), .busy(busy[0])
  );

  aes_iter_core #(.KEY_BITS(256)) u_aes256 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data1), .in_key(in_key1),
`ifdef AES_ABORT_EN
    .abort(abort[1]),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data1), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference cipher ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [255:0] key, input int nk);
    int          nr = nk + 6;
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc [10];
    logic [7:0]  s [4][4];
    logic [7:0]  t [4][4];
    logic [7:0]  acc;
    logic [7:0]  coef [4];
    logic [127:0] res;
    rc   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-i)-1 -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rc[i/nk-1], 24'h0};
      else if (nk > 6 && i % nk == 4) tmp = sub_w(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int k = 1; k <= nr; k++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (k < nr) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j-r+4)%4], t[j][c]);
          end else begin
            acc = t[r][c];
          end
          s[r][c] = acc ^ w[4*k+c][31-8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] get_od(input int sel);
    return (sel != 0) ? out_data1 : out_data0;
  endfunction

  task automatic drive(input int sel, input logic [127:0] pt, input logic [255:0] key, input logic v);
    if (sel == 0) begin
      in_valid[0] = v; in_data0 = pt; in_key0 = key[127:0];
    end else begin
      in_valid[1] = v; in_data1 = pt; in_key1 = key;
    end
  endtask

  task automatic accept(input int sel, input logic [127:0] pt, input logic [255:0] key);
    int n = 0;
    drive(sel, pt, key, 1'b1);
    #1;
    while (!in_ready[sel] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", 128'(in_ready[sel]), 128'd1);
    @(posedge clk); #1;
    drive(sel, rand128(), {rand128(), rand128()}, 1'b0);
  endtask

  task automatic wait_result(input int sel, input int nr, input logic [127:0] exp, input bit jitter);
    int lat = 0;
    int nbusy = 0;
    while (!out_valid[sel] && lat < 40) begin
      if (busy[sel]) nbusy++;
      if (jitter) drive(sel, rand128(), {rand128(), rand128()}, 1'b0);
      @(posedge clk); #1; lat++;
    end
    check("latency", 128'(lat), 128'(nr));
    check("busy_cycles", 128'(nbusy), 128'(nr));
    check("ciphertext", get_od(sel), exp);
  endtask

  task automatic consume_idle(input int sel);
    @(posedge clk); #1;
    check("ov_drop", 128'(out_valid[sel]), 128'd0);
    check("idle_ready", 128'(in_ready[sel]), 128'd1);
  endtask

  task automatic run_block(input int sel, input logic [127:0] pt, input logic [255:0] key,
                           input logic [127:0] exp, input bit jitter);
    accept(sel, pt, key);
    wait_result(sel, (sel != 0) ? 14 : 10, exp, jitter);
    consume_idle(sel);
  endtask

  task automatic expect_no_valid(input int sel, input string tag);
    int seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid[sel]) seen++;
    end
    check(tag, 128'(seen), 128'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int           sel;
    logic [127:0] pt, exp;
    logic [255:0] key;

    build_sbox();
    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b11;
    in_data0 = '0; in_data1 = '0; in_key0 = '0; in_key1 = '0;
`ifdef AES_ABORT_EN
    abort = 2'b00;
`endif
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 128'(in_ready[i]), 128'd0);
      check("rst_out_valid", 128'(out_valid[i]), 128'd0);
      check("rst_busy", 128'(busy[i]), 128'd0);
      check("rst_out_data", get_od(i), 128'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready128", 128'(in_ready[0]), 128'd1);
    check("post_rst_ready256", 128'(in_ready[1]), 128'd1);

    run_block(0, PT, K128, C128, 1'b0);
    run_block(1, PT, K256, C256, 1'b0);

    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 1));
      pt  = rand128();
      key = {rand128(), rand128()};
      if (sel == 0) key[255:128] = '0;
      exp = ref_enc(pt, key, (sel != 0) ? 8 : 4);
      run_block(sel, pt, key, exp, 1'($urandom_range(0, 1)));
    end

    run_block(0, PT, K128, C128, 1'b1);
    run_block(1, PT, K256, C256, 1'b1);

    // Backpressure, then back-to-back acceptance on the consuming edge
    out_ready[0] = 1'b0;
    accept(0, PT, K128);
    wait_result(0, 10, C128, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 128'(out_valid[0]), 128'd1);
      check("bp_out_data", out_data0, C128);
      check("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    pt  = rand128();
    key = {128'h0, rand128()};
    exp = ref_enc(pt, key, 4);
    drive(0, pt, key, 1'b1);
    out_ready[0] = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;
    drive(0, rand128(), {rand128(), rand128()}, 1'b0);
    check("b2b_ov_low", 128'(out_valid[0]), 128'd0);
    wait_result(0, 10, exp, 1'b0);
    consume_idle(0);

    // Reset in the middle of an AES-256 block
    accept(1, PT, K256);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid[1]), 128'd0);
    check("mid_rst_busy", 128'(busy[1]), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready[1]), 128'd0);
    check("mid_rst_out_data128", out_data0, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_no_valid(1, "mid_rst_no_valid");
    run_block(1, PT, K256, C256, 1'b0);
    run_block(0, PT, K128, C128, 1'b0);

`ifdef AES_ABORT_EN
    accept(0, PT, K128);
    repeat (2) @(posedge clk);
    #1;
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    check("abort_in_ready", 128'(in_ready[0]), 128'd1);
    check("abort_out_valid", 128'(out_valid[0]), 128'd0);
    check("abort_busy", 128'(busy[0]), 128'd0);
    check("abort_out_data", out_data0, 128'd0);
    expect_no_valid(0, "abort_no_valid");
    run_block(0, PT, K128, C128, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
